// File: rtl/filtro_sensores.sv
// Tank-level float switch conditioning: two-flop sync, per-bit debounce,
// consistency check on the level pattern and a sticky fault on persistent inconsistency.
module filtro_sensores #(
  parameter int DEB_CYCLES   = 50000,
  parameter int FAULT_CYCLES = 4096,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] sensores_i,
  input  logic       clear_i,
  output logic [2:0] sensores_o,
  output logic       cambio_o,
  output logic       inconsistente_o,
  output logic       fault_o
);

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] FAULT_LAST = CNT_W'(FAULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [2:0]       s1;
  logic [2:0]       s2;
  logic [2:0]       d;
  logic [CNT_W-1:0] c [3];
  logic [CNT_W-1:0] f;
  logic             consistente;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 3'b000;
      s2 <= 3'b000;
    end else begin
      s1 <= sensores_i;
      s2 <= s1;
    end
  end

  // Any single cycle of agreement between s2 and d restarts that bit's count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d <= 3'b000;
      for (int i = 0; i < 3; i++) c[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (s2[i] == d[i]) begin
          c[i] <= '0;
        end else if (c[i] == DEB_LAST) begin
          d[i] <= s2[i];
          c[i] <= '0;
        end else begin
          c[i] <= c[i] + CNT_ONE;
        end
      end
    end
  end

  // Water can only be present at a level if every lower level is also wet.
  always_comb begin
    consistente = 1'b0;
    case (d)
      3'b000, 3'b001, 3'b011, 3'b111: consistente = 1'b1;
      default:                        consistente = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sensores_o      <= 3'b000;
      cambio_o        <= 1'b0;
      inconsistente_o <= 1'b0;
    end else begin
      inconsistente_o <= ~consistente;
      if (consistente && (d != sensores_o)) begin
        sensores_o <= d;
        cambio_o   <= 1'b1;
      end else begin
        cambio_o   <= 1'b0;
      end
    end
  end

  // f saturates at FAULT_LAST once the fault latches, so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f       <= '0;
      fault_o <= 1'b0;
    end else if (clear_i) begin
      f       <= '0;
      fault_o <= 1'b0;
    end else if (consistente) begin
      f       <= '0;
    end else if (f == FAULT_LAST) begin
      fault_o <= 1'b1;
    end else begin
      f       <= f + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_filtro_sensores.sv
// Bench for filtro_sensores: directed scenarios plus random patterns, all checked
// against a sliding-window reference model of the debounce and fault rules.
module tb_filtro_sensores;

  localparam int DEB = 4;
  localparam int FLT = 3;

  logic       clk;
  logic       rst_n;
  logic [2:0] sensores_i;
  logic       clear_i;
  logic [2:0] sensores_o;
  logic       cambio_o;
  logic       inconsistente_o;
  logic       fault_o;

  int tests = 0;
  int fails = 0;

  filtro_sensores #(
    .DEB_CYCLES  (DEB),
    .FAULT_CYCLES(FLT),
    .CNT_W       (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sensores_i     (sensores_i),
    .clear_i        (clear_i),
    .sensores_o     (sensores_o),
    .cambio_o       (cambio_o),
    .inconsistente_o(inconsistente_o),
    .fault_o        (fault_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a bit's debounced value flips once the last DEB synchronised
  // samples all disagree with it; the fault latches once the last FLT edges were
  // all inconsistent with clear low.
  logic [2:0] m_s1, m_s2, m_d, m_so;
  logic       m_cam, m_inc, m_fault;
  logic [2:0] s2_hist[$];
  bit         bad_hist[$];

  function automatic bit pattern_ok(input logic [2:0] p);
    return (p == 3'd0) || (p == 3'd1) || (p == 3'd3) || (p == 3'd7);
  endfunction

  function automatic void model_reset();
    m_s1 = 3'b000; m_s2 = 3'b000; m_d = 3'b000; m_so = 3'b000;
    m_cam = 1'b0; m_inc = 1'b0; m_fault = 1'b0;
    s2_hist.delete();
    bad_hist.delete();
  endfunction

  task automatic tick();
    logic [2:0] nd;
    bit ok, flip, all_bad;
    if (!rst_n) begin
      model_reset();
    end else begin
      ok = pattern_ok(m_d);
      s2_hist.push_back(m_s2);
      if (s2_hist.size() > DEB) void'(s2_hist.pop_front());
      nd = m_d;
      if (s2_hist.size() == DEB) begin
        for (int i = 0; i < 3; i++) begin
          flip = 1'b1;
          foreach (s2_hist[k]) if (s2_hist[k][i] == m_d[i]) flip = 1'b0;
          if (flip) nd[i] = ~m_d[i];
        end
      end
      bad_hist.push_back(!clear_i && !ok);
      if (bad_hist.size() > FLT) void'(bad_hist.pop_front());
      m_inc = !ok;
      if (ok && (m_d != m_so)) begin
        m_so  = m_d;
        m_cam = 1'b1;
      end else begin
        m_cam = 1'b0;
      end
      if (clear_i) begin
        m_fault = 1'b0;
      end else if (bad_hist.size() == FLT) begin
        all_bad = 1'b1;
        foreach (bad_hist[k]) if (!bad_hist[k]) all_bad = 1'b0;
        if (all_bad) m_fault = 1'b1;
      end
      m_s2 = m_s1;
      m_s1 = sensores_i;
      m_d  = nd;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sensores_i = 3'b000;
    clear_i = 1'b0;
    #1;
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int seen;
    do_reset();
    for (int n = 0; n < 50; n++) begin
      tick();
      tests++;
      if ({sensores_o, cambio_o, inconsistente_o, fault_o} !== 6'b000_000) begin
        fails++;
        $display("FAIL reset_idle cycle %0d got %b exp 000000", n,
                 {sensores_o, cambio_o, inconsistente_o, fault_o});
      end
    end
    sensores_i = 3'b001;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    tests++;
    if ({sensores_o, cambio_o, inconsistente_o, fault_o} !== 6'b000_000) begin
      fails++;
      $display("FAIL reset_async got %b exp 000000", {sensores_o, cambio_o, inconsistente_o, fault_o});
    end
    repeat (2) tick();
    rst_n = 1'b1;
    seen = -1;
    for (int n = 0; n < 15; n++) begin
      tick();
      if (sensores_o == 3'b001 && seen < 0) seen = n;
      tests++;
      if ({sensores_o, cambio_o, inconsistente_o, fault_o} !== {m_so, m_cam, m_inc, m_fault}) begin
        fails++;
        $display("FAIL reset_model edge %0d got %b exp %b", n,
                 {sensores_o, cambio_o, inconsistente_o, fault_o}, {m_so, m_cam, m_inc, m_fault});
      end
    end
    tests++;
    if (seen !== DEB + 2) begin
      fails++;
      $display("FAIL reset_relatency got edge %0d exp edge %0d", seen, DEB + 2);
    end
  endtask

  task automatic test_change();
    int pulses, first;
    do_reset();
    repeat (10) tick();
    sensores_i = 3'b001;
    pulses = 0;
    first = -1;
    for (int n = 0; n < 15; n++) begin
      tick();
      if (cambio_o) begin
        pulses++;
        if (first < 0) first = n;
      end
      tests++;
      if ({sensores_o, cambio_o, inconsistente_o, fault_o} !== {m_so, m_cam, m_inc, m_fault}) begin
        fails++;
        $display("FAIL change_model edge %0d got %b exp %b", n,
                 {sensores_o, cambio_o, inconsistente_o, fault_o}, {m_so, m_cam, m_inc, m_fault});
      end
    end
    tests++;
    if (pulses !== 1 || first !== DEB + 2 || sensores_o !== 3'b001) begin
      fails++;
      $display("FAIL change_latency got pulses=%0d edge=%0d out=%b exp pulses=1 edge=%0d out=001",
               pulses, first, sensores_o, DEB + 2);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    repeat (5) tick();
    for (int rep = 0; rep < 6; rep++) begin
      for (int k = 0; k < 4; k++) begin
        sensores_i = (k < 3) ? 3'b001 : 3'b000;
        tick();
        tests++;
        if (sensores_o !== 3'b000 || cambio_o !== 1'b0 || m_so !== 3'b000) begin
          fails++;
          $display("FAIL glitch got out=%b cambio=%b exp out=000 cambio=0", sensores_o, cambio_o);
        end
      end
    end
  endtask

  task automatic test_fill();
    logic [2:0] pats [3];
    int pulses;
    pats[0] = 3'b001; pats[1] = 3'b011; pats[2] = 3'b111;
    do_reset();
    pulses = 0;
    for (int p = 0; p < 3; p++) begin
      sensores_i = pats[p];
      for (int n = 0; n < 20; n++) begin
        tick();
        if (cambio_o) pulses++;
        tests++;
        if ({sensores_o, cambio_o, inconsistente_o, fault_o} !== {m_so, m_cam, m_inc, m_fault}) begin
          fails++;
          $display("FAIL fill_model got %b exp %b",
                   {sensores_o, cambio_o, inconsistente_o, fault_o}, {m_so, m_cam, m_inc, m_fault});
        end
      end
      tests++;
      if (sensores_o !== pats[p]) begin
        fails++;
        $display("FAIL fill_step got %b exp %b", sensores_o, pats[p]);
      end
    end
    tests++;
    if (pulses !== 3) begin
      fails++;
      $display("FAIL fill_pulses got %0d exp 3", pulses);
    end
  endtask

  task automatic test_fault();
    int inc_at, f_at;
    do_reset();
    sensores_i = 3'b011;
    repeat (20) tick();
    sensores_i = 3'b101;
    inc_at = -1;
    f_at = -1;
    for (int n = 0; n < 15; n++) begin
      tick();
      if (inconsistente_o && inc_at < 0) inc_at = n;
      if (fault_o && f_at < 0) f_at = n;
      tests++;
      if (sensores_o !== 3'b011 || cambio_o !== 1'b0) begin
        fails++;
        $display("FAIL fault_hold got out=%b cambio=%b exp out=011 cambio=0", sensores_o, cambio_o);
      end
    end
    tests++;
    if (inc_at !== DEB + 2 || f_at !== DEB + 1 + FLT) begin
      fails++;
      $display("FAIL fault_timing got inc=%0d fault=%0d exp inc=%0d fault=%0d",
               inc_at, f_at, DEB + 2, DEB + 1 + FLT);
    end
    sensores_i = 3'b011;
    repeat (12) tick();
    tests++;
    if (inconsistente_o !== 1'b0 || fault_o !== 1'b1 || sensores_o !== 3'b011) begin
      fails++;
      $display("FAIL fault_sticky got inc=%b fault=%b out=%b exp inc=0 fault=1 out=011",
               inconsistente_o, fault_o, sensores_o);
    end
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    tests++;
    if (fault_o !== 1'b0 || m_fault !== 1'b0) begin
      fails++;
      $display("FAIL fault_clear got %b exp 0", fault_o);
    end
  endtask

  task automatic test_clear_hold();
    int f_at;
    do_reset();
    clear_i = 1'b1;
    sensores_i = 3'b010;
    for (int n = 0; n < 20; n++) begin
      tick();
      tests++;
      if (fault_o !== 1'b0) begin
        fails++;
        $display("FAIL clear_hold edge %0d got fault=%b exp 0", n, fault_o);
      end
    end
    clear_i = 1'b0;
    f_at = -1;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (fault_o && f_at < 0) f_at = n;
      tests++;
      if ({sensores_o, cambio_o, inconsistente_o, fault_o} !== {m_so, m_cam, m_inc, m_fault}) begin
        fails++;
        $display("FAIL clear_model got %b exp %b",
                 {sensores_o, cambio_o, inconsistente_o, fault_o}, {m_so, m_cam, m_inc, m_fault});
      end
    end
    tests++;
    if (f_at !== FLT - 1) begin
      fails++;
      $display("FAIL clear_release got edge %0d exp edge %0d", f_at, FLT - 1);
    end
  endtask

  task automatic test_random();
    int hold;
    do_reset();
    for (int seg = 0; seg < 250; seg++) begin
      sensores_i = 3'($urandom_range(0, 7));
      clear_i = ($urandom_range(0, 15) == 0);
      hold = $urandom_range(1, 9);
      for (int n = 0; n < hold; n++) begin
        tick();
        tests++;
        if ({sensores_o, cambio_o, inconsistente_o, fault_o} !== {m_so, m_cam, m_inc, m_fault}) begin
          fails++;
          $display("FAIL random seg %0d got %b exp %b", seg,
                   {sensores_o, cambio_o, inconsistente_o, fault_o}, {m_so, m_cam, m_inc, m_fault});
        end
      end
    end
    clear_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    sensores_i = 3'b000;
    clear_i = 1'b0;
    model_reset();
    test_reset();
    test_change();
    test_glitch();
    test_fill();
    test_fault();
    test_clear_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
